// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch unit with a small in-order buffer.
//
// The fetch PC addresses a combinational instruction memory. Each cycle the
// returned word is pushed into a circular FIFO together with its PC, provided
// there is room (or the head leaves in the same cycle). Decode drains the head
// with a valid/ready handshake. A redirect flushes the buffer and reloads the
// fetch PC with the target, forced to word alignment. A misaligned target
// raises a one-cycle align_err_o pulse.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   fetch_en_i           fetch permitted this cycle
//   imem_addr_o/rdata_i  combinational instruction memory port
//   redirect_i/pc_i      branch/jump redirect request and target
//   instr_valid_o/o/pc_o head of the instruction buffer
//   instr_ready_i        decode accepts the head
//   align_err_o          pulse: last redirect target was not word-aligned
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2              // 2 or 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        align_err_o
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        buf_q [BUF_DEPTH];
    logic [31:0]   fetch_pc;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          full, push, pop;

    assign imem_addr_o   = fetch_pc;
    assign full          = (count == CW'(BUF_DEPTH));
    assign instr_valid_o = (count != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    // A full buffer may still accept a word when the head leaves this cycle.
    assign push          = fetch_en_i && !redirect_i && (!full || pop);

    // Gate the head with valid so unreset storage never reaches the outputs.
    assign instr_o    = instr_valid_o ? buf_q[rptr].instr : 32'h0;
    assign instr_pc_o = instr_valid_o ? buf_q[rptr].pc    : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= RESET_PC;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            align_err_o <= 1'b0;
        end else begin
            align_err_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i) begin
                // Flush wins over any pop/push in the same cycle.
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wptr     <= (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
                end
                if (pop)
                    rptr <= (rptr == LAST_IDX) ? '0 : rptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
        end
    end

    // Data storage is write-only on push; no reset needed.
    always_ff @(posedge clk_i) begin
        if (push)
            buf_q[wptr] <= '{pc: fetch_pc, instr: imem_rdata_i};
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (RESET_PC=0, BUF_DEPTH=2). The instruction
// memory returns its own address as data. Inputs change and outputs are
// sampled on the falling edge; all DUT outputs depend only on state.
module tb_instr_fetch;

    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    instr_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(BD)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_en_i    (fetch_en),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready),
        .align_err_o   (align_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, ".pc"}, instr_pc, pc);
        chk({tag, ".instr"}, instr, pc);
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst.valid", {31'b0, instr_valid}, 32'd0);
        chk("rst.addr",  imem_addr, 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.pc",    instr_pc, 32'h0);
        chk("rst.align", {31'b0, align_err}, 32'd0);

        // Streaming: one instruction per cycle from reset release
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_head("stream", 32'(4 * k));
            chk("stream.addr", imem_addr, 32'(4 * k + 4));
        end

        // Backpressure from an empty buffer: flush to 0 with ready low
        redirect = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0;
        @(negedge clk);
        chk("bp.flush.valid", {31'b0, instr_valid}, 32'd0);
        chk("bp.flush.addr",  imem_addr, 32'h0);
        redirect = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp.hold.addr", imem_addr, 32'(4 * BD));
        chk_head("bp.hold", 32'h0);
        instr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk_head("bp.resume", 32'(4 * (j + 1)));
        end

        // Redirect with a full buffer and a pop pending
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        chk("redir.valid", {31'b0, instr_valid}, 32'd0);
        chk("redir.addr",  imem_addr, 32'h100);
        chk("redir.instr", instr, 32'h0);
        chk("redir.align", {31'b0, align_err}, 32'd0);
        redirect = 1'b0;
        @(negedge clk);
        chk_head("redir.first", 32'h100);

        // Misaligned redirect
        redirect = 1'b1; redirect_pc = 32'h0000_0106;
        @(negedge clk);
        chk("mis.addr",  imem_addr, 32'h104);
        chk("mis.align", {31'b0, align_err}, 32'd1);
        redirect = 1'b0;
        @(negedge clk);
        chk("mis.align_clr", {31'b0, align_err}, 32'd0);
        chk_head("mis.first", 32'h104);

        // Address wrap at the top of memory
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        @(negedge clk);
        chk_head("wrap.top", 32'hFFFF_FFFC);
        chk("wrap.addr1", imem_addr, 32'h0);
        @(negedge clk);
        chk_head("wrap.zero", 32'h0);
        chk("wrap.addr2", imem_addr, 32'h4);

        // Fetch disabled: buffer drains, PC holds
        fetch_en = 1'b0;
        @(negedge clk);
        chk("dis.valid", {31'b0, instr_valid}, 32'd0);
        chk("dis.addr",  imem_addr, 32'h4);
        @(negedge clk);
        chk("dis.addr2", imem_addr, 32'h4);

        // Fill the buffer, then reset mid-stream
        fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("full.addr", imem_addr, 32'hC);
        chk_head("full.head", 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst.addr",  imem_addr, 32'h0);
        chk("mrst.pc",    instr_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        chk_head("mrst.first", 32'h0);
        @(negedge clk);
        chk_head("mrst.second", 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL expose parameter BUF_DEPTH, default 2, meaning the number of instruction-buffer entries; legal values are 2 or 4.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 fetch_en_i  input  1  fetch permitted this cycle.
REQ-006 imem_addr_o  output  32  byte address to the combinational instruction memory.
REQ-007 imem_rdata_i  input  32  instruction word returned combinationally for imem_addr_o in the same cycle.
REQ-008 redirect_i  input  1  branch/jump redirect request.
REQ-009 redirect_pc_i  input  32  redirect target byte address.
REQ-010 instr_valid_o  output  1  buffer head holds a valid instruction.
REQ-011 instr_o  output  32  head instruction word.
REQ-012 instr_pc_o  output  32  PC of the head instruction.
REQ-013 instr_ready_i  input  1  decode accepts the head this cycle.
REQ-014 align_err_o  output  1  one-cycle pulse: redirect target was not word-aligned.

Function
REQ-015 The block SHALL hold a 32-bit fetch_pc register and drive imem_addr_o = fetch_pc combinationally at all times.
REQ-016 The block SHALL hold a circular FIFO of BUF_DEPTH entries {pc, instr}, with read/write pointers and an occupancy count of 0..BUF_DEPTH.
REQ-017 pop SHALL be instr_valid_o && instr_ready_i; the head SHALL advance on the same clock edge.
REQ-018 push SHALL be fetch_en_i && !redirect_i && (count < BUF_DEPTH || pop).
REQ-019 A push SHALL write {fetch_pc, imem_rdata_i} at the write pointer and update fetch_pc to fetch_pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Simultaneous push and pop SHALL leave count unchanged. A push on a full buffer is legal only in the same cycle as a pop.
REQ-021 When !fetch_en_i, fetch_pc SHALL hold, no push SHALL occur, and pops SHALL continue to drain the buffer.
REQ-022 instr_valid_o SHALL equal (count != 0). instr_o and instr_pc_o SHALL be the head entry when valid and 32'h0 when empty.
REQ-023 Redirect SHALL have highest priority:
- all entries flushed (count=0, pointers=0);
- fetch_pc <= {redirect_pc_i[31:2], 2'b00};
- no push that cycle;
- any pop that cycle discarded, since the head is flushed;
- instr_valid_o SHALL be 0 in the following cycle.
REQ-024 align_err_o SHALL be registered and equal 1 for exactly the cycle after a redirect with redirect_pc_i[1:0] != 0; otherwise 0.
REQ-025 Pointers SHALL wrap from BUF_DEPTH-1 to 0. Instructions SHALL exit in strict push order.
REQ-026 Latency: an instruction at fetch_pc in cycle N SHALL appear at instr_o no earlier than cycle N+1. With instr_ready_i held at 1, sustained throughput SHALL be one instruction per cycle.

Reset
REQ-027 While rst_ni = 0, asynchronously:
- fetch_pc = RESET_PC and imem_addr_o = RESET_PC;
- count = 0, both pointers = 0;
- instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, align_err_o = 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries. The first push after deassertion SHALL use RESET_PC.
REQ-029 FIFO data storage need not be reset, but no unreset value SHALL reach instr_o or instr_pc_o.

Verification
REQ-030 Streaming: memory word = address, fetch_en_i=1, instr_ready_i=1 -> imem_addr_o 0,4,8,...; instr_pc_o/instr_o pairs (0,0),(4,4),(8,8) on consecutive cycles starting the cycle after reset release.
REQ-031 Backpressure: instr_ready_i=0 for 5 cycles -> exactly BUF_DEPTH pushes, then fetch_pc holds at 4*BUF_DEPTH. After instr_ready_i=1, ordering continues with no loss or duplication.
REQ-032 Redirect with 2 entries buffered, redirect_pc_i=32'h0000_0100 -> next cycle instr_valid_o=0 and imem_addr_o=0x100. The next delivered instruction has instr_pc_o=0x100.
REQ-033 Misaligned redirect, redirect_pc_i=32'h0000_0106 -> fetch_pc=0x104 and align_err_o=1 for exactly one cycle.
REQ-034 Wrap: redirect to 32'hFFFF_FFFC, two pushes -> instr_pc_o sequence FFFF_FFFC then 0000_0000.
REQ-035 Reset mid-stream with a full buffer:
- during reset: instr_valid_o=0 and imem_addr_o=RESET_PC;
- after release: the first delivered instr_pc_o = RESET_PC.
